mem_arbiter: RTL

- Two-port arbiter upstream of the memory/peripheral controller: instruction-fetch (I) and load/store (D) requesters share the single memory request interface.
- Serialises requests round-robin and drives the controller's active-low ce handshake.
- Holds every request field stable for the whole transaction.
- Returns read data, a one-cycle done pulse and a fault flag to the granted port; a watchdog aborts hung transactions.

---
 rtl/mem_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory-controller request interface between an instruction-fetch
// port (i_*) and a load/store port (d_*).
//
// Requests are granted round-robin. Every request field is registered and held stable for
// the whole transaction. The controller is driven through the active-low mem_ce handshake.
// Read data, a one-cycle done pulse and a fault flag go back to the granted port. A watchdog
// aborts a transaction that stays busy for too long.
//
// Ports:
//   clk, reset        system clock; asynchronous active-high reset
//   i_req/i_addr      fetch request (held until i_done) and fetch address
//   i_rdata/i_done/i_fault   registered fetch data, completion pulse, fault qualifier
//   d_req/d_addr/d_funct3/d_wdata/d_we   load/store request fields
//   d_rdata/d_done/d_fault   registered load data, completion pulse, fault qualifier
//   mem_ce            active-low transaction enable to the controller
//   mem_addr/mem_funct3/mem_datain/mem_memwrite   registered request fields to the controller
//   mem_dataout/mem_busy/mem_valid/mem_fault      controller responses
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_done,
    output logic        i_fault,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_wdata,
    input  logic        d_we,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_fault,
    output logic        mem_ce,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_datain,
    output logic        mem_memwrite,
    input  logic [31:0] mem_dataout,
    input  logic        mem_busy,
    input  logic        mem_valid,
    input  logic        mem_fault
);

    localparam int unsigned TimerW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TimerW-1:0] TimerLast =
        (TIMEOUT_CYCLES > 0) ? TimerW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StRelease} state_e;

    state_e state_q, state_d;

    // 1 = load/store port, 0 = fetch port
    logic last_grant_q, last_grant_d;
    logic owner_q, owner_d;
    logic [TimerW-1:0] timer_q, timer_d;

    logic        mem_ce_d, mem_memwrite_d;
    logic [31:0] mem_addr_d, mem_datain_d, i_rdata_d, d_rdata_d;
    logic [2:0]  mem_funct3_d;
    logic        i_done_d, i_fault_d, d_done_d, d_fault_d;

    // Completion is signalled by busy dropping; read-valid carries no extra information.
    logic unused_valid;
    assign unused_valid = mem_valid;

    // Round-robin: on contention the port that was not served last wins.
    logic grant_i, grant_d;
    assign grant_i = i_req & (~d_req | last_grant_q);
    assign grant_d = d_req & (~i_req | ~last_grant_q);

    logic wait_done, wait_timeout;
    assign wait_done    = (state_q == StWait) & ~mem_busy;
    assign wait_timeout = (TIMEOUT_CYCLES != 0) && (state_q == StWait) && mem_busy &&
                          (timer_q == TimerLast);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (grant_i | grant_d) state_d = StIssue;
            StIssue:   state_d = StWait;
            StWait:    if (wait_done | wait_timeout) state_d = StRelease;
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and bookkeeping
    always_comb begin
        mem_ce_d       = mem_ce;
        mem_addr_d     = mem_addr;
        mem_funct3_d   = mem_funct3;
        mem_datain_d   = mem_datain;
        mem_memwrite_d = mem_memwrite;
        i_rdata_d      = i_rdata;
        d_rdata_d      = d_rdata;
        // done/fault default low so they pulse for exactly the RELEASE cycle
        i_done_d       = 1'b0;
        i_fault_d      = 1'b0;
        d_done_d       = 1'b0;
        d_fault_d      = 1'b0;
        last_grant_d   = last_grant_q;
        owner_d        = owner_q;
        timer_d        = timer_q;

        unique case (state_q)
            StIdle: begin
                if (grant_i) begin
                    mem_ce_d       = 1'b0;
                    mem_addr_d     = i_addr;
                    mem_funct3_d   = 3'b010;
                    mem_datain_d   = '0;
                    mem_memwrite_d = 1'b0;
                    owner_d        = 1'b0;
                    last_grant_d   = 1'b0;
                end else if (grant_d) begin
                    mem_ce_d       = 1'b0;
                    mem_addr_d     = d_addr;
                    mem_funct3_d   = d_funct3;
                    mem_datain_d   = d_wdata;
                    mem_memwrite_d = d_we;
                    owner_d        = 1'b1;
                    last_grant_d   = 1'b1;
                end
            end
            StIssue: begin
                timer_d = '0;
            end
            StWait: begin
                if (wait_done) begin
                    mem_ce_d = 1'b1;
                    if (owner_q) begin
                        d_done_d  = 1'b1;
                        d_fault_d = mem_fault;
                        if (!mem_memwrite) d_rdata_d = mem_dataout;
                    end else begin
                        i_done_d  = 1'b1;
                        i_fault_d = mem_fault;
                        if (!mem_memwrite) i_rdata_d = mem_dataout;
                    end
                end else if (wait_timeout) begin
                    mem_ce_d = 1'b1;
                    if (owner_q) begin
                        d_done_d  = 1'b1;
                        d_fault_d = 1'b1;
                    end else begin
                        i_done_d  = 1'b1;
                        i_fault_d = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StRelease: begin
                mem_ce_d = 1'b1;
            end
            default: begin
                mem_ce_d = 1'b1;
            end
        endcase
    end

    // Output and bookkeeping registers; reset drops mem_ce immediately to abandon any access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_ce       <= 1'b1;
            mem_addr     <= '0;
            mem_funct3   <= '0;
            mem_datain   <= '0;
            mem_memwrite <= 1'b0;
            i_rdata      <= '0;
            d_rdata      <= '0;
            i_done       <= 1'b0;
            i_fault      <= 1'b0;
            d_done       <= 1'b0;
            d_fault      <= 1'b0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            timer_q      <= '0;
        end else begin
            mem_ce       <= mem_ce_d;
            mem_addr     <= mem_addr_d;
            mem_funct3   <= mem_funct3_d;
            mem_datain   <= mem_datain_d;
            mem_memwrite <= mem_memwrite_d;
            i_rdata      <= i_rdata_d;
            d_rdata      <= d_rdata_d;
            i_done       <= i_done_d;
            i_fault      <= i_fault_d;
            d_done       <= d_done_d;
            d_fault      <= d_fault_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            timer_q      <= timer_d;
        end
    end

endmodule
